// File: rtl/arbitro_2a1.sv
// arbitro_2a1: round-robin arbiter driving the select of a 2:1 multiplexer.
//
// Two requesters (X, Y) compete for the mux. Idle selects nothing (00), X is
// selected with 01, Y with 10; 11 is never produced. A grant is held while its
// request stays high and moves directly to the other requester on release.
// Ties from idle go to the requester not served last.
//
// Optional feature, macro ARBITRO_LIMITE_RAFAGA_EN: a burst counter forces the
// grant over to a waiting requester after MAX_RAFAGA consecutive cycles.
// Without the macro the counter is absent and MAX_RAFAGA is ignored.
//
// Parameters:
//   MAX_RAFAGA  max consecutive grant cycles while the other side waits (2..255)
// Ports:
//   Reloj       clock, rising edge
//   Reset       synchronous active-high reset
//   SolicitudX  request from X
//   SolicitudY  request from Y
//   Selector    mux select (01 = X, 10 = Y, 00 = idle)
//   ConcesionX  grant to X (Selector[0])
//   ConcesionY  grant to Y (Selector[1])

module arbitro_2a1 #(
  parameter int unsigned MAX_RAFAGA = 8
) (
  input  logic       Reloj,
  input  logic       Reset,
  input  logic       SolicitudX,
  input  logic       SolicitudY,
  output logic [1:0] Selector,
  output logic       ConcesionX,
  output logic       ConcesionY
);

  // Encodings equal the select code, so outputs decode straight from the state register.
  typedef enum logic [1:0] {
    StLibre     = 2'b00,
    StConcedeX  = 2'b01,
    StConcedeY  = 2'b10
  } estado_e;

  estado_e estado_q, estado_d;

  // Last served requester: 0 = X, 1 = Y.
  logic ultimo_q, ultimo_d;

`ifdef ARBITRO_LIMITE_RAFAGA_EN
  localparam logic [7:0] CntMax = 8'(MAX_RAFAGA - 1);

  logic [7:0] rafaga_q, rafaga_d;
  logic       limite;

  assign limite = (rafaga_q == CntMax);
`else
  logic limite;
  logic unused_max_rafaga;

  assign limite            = 1'b0;
  assign unused_max_rafaga = ^MAX_RAFAGA;
`endif

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StLibre: begin
        if (SolicitudX && SolicitudY) begin
          estado_d = ultimo_q ? StConcedeX : StConcedeY;
        end else if (SolicitudX) begin
          estado_d = StConcedeX;
        end else if (SolicitudY) begin
          estado_d = StConcedeY;
        end
      end
      StConcedeX: begin
        if (!SolicitudX) begin
          estado_d = SolicitudY ? StConcedeY : StLibre;
        end else if (limite && SolicitudY) begin
          estado_d = StConcedeY;
        end
      end
      StConcedeY: begin
        if (!SolicitudY) begin
          estado_d = SolicitudX ? StConcedeX : StLibre;
        end else if (limite && SolicitudX) begin
          estado_d = StConcedeX;
        end
      end
      default: estado_d = StLibre;
    endcase
  end

  always_comb begin
    ultimo_d = ultimo_q;
    if (estado_d == StConcedeX) begin
      ultimo_d = 1'b0;
    end else if (estado_d == StConcedeY) begin
      ultimo_d = 1'b1;
    end
  end

`ifdef ARBITRO_LIMITE_RAFAGA_EN
  // Clears on any grant change (including to/from idle), saturates while held.
  always_comb begin
    rafaga_d = 8'd0;
    if (estado_d == estado_q && estado_q != StLibre) begin
      rafaga_d = limite ? rafaga_q : rafaga_q + 8'd1;
    end
  end

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      rafaga_q <= 8'd0;
    end else begin
      rafaga_q <= rafaga_d;
    end
  end
`endif

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      estado_q <= StLibre;
      ultimo_q <= 1'b1;
    end else begin
      estado_q <= estado_d;
      ultimo_q <= ultimo_d;
    end
  end

  assign Selector   = estado_q;
  assign ConcesionX = estado_q[0];
  assign ConcesionY = estado_q[1];

endmodule

// File: tb/tb_arbitro_2a1.sv
// Directed testbench for arbitro_2a1 with MAX_RAFAGA = 4. Covers reset, single
// requester, handoff, round-robin ties, reset mid-grant, and either the burst
// limit (ARBITRO_LIMITE_RAFAGA_EN defined) or unlimited holding (undefined).

module tb_arbitro_2a1;

  logic       Reloj = 1'b0;
  logic       Reset = 1'b1;
  logic       SolicitudX = 1'b0;
  logic       SolicitudY = 1'b0;
  logic [1:0] Selector;
  logic       ConcesionX;
  logic       ConcesionY;

  int n_tests = 0;
  int n_fail  = 0;
  bit inv_en  = 1'b0;

  arbitro_2a1 #(
    .MAX_RAFAGA (4)
  ) dut (
    .Reloj      (Reloj),
    .Reset      (Reset),
    .SolicitudX (SolicitudX),
    .SolicitudY (SolicitudY),
    .Selector   (Selector),
    .ConcesionX (ConcesionX),
    .ConcesionY (ConcesionY)
  );

  always #5 Reloj = ~Reloj;

  task automatic check_eq(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs, let one rising edge pass, check the select just after it.
  task automatic ciclo(input logic rst, input logic x, input logic y,
                       input logic [1:0] exp, input string tag);
    Reset      = rst;
    SolicitudX = x;
    SolicitudY = y;
    @(posedge Reloj);
    #1;
    check_eq(tag, Selector, exp);
  endtask

  // Invariants, sampled on the falling edge.
  always @(negedge Reloj) begin
    if (inv_en) begin
      check_eq("inv_no11", {1'b0, (Selector == 2'b11)}, 2'b00);
      check_eq("inv_grants", {ConcesionY, ConcesionX}, Selector);
    end
  end

  initial begin
    // Reset overrides requests.
    for (int i = 0; i < 3; i++) ciclo(1'b1, 1'b1, 1'b1, 2'b00, "reset_hold");
    inv_en = 1'b1;
    ciclo(1'b0, 1'b1, 1'b1, 2'b01, "reset_release_x_wins");
    ciclo(1'b0, 1'b0, 1'b0, 2'b00, "reset_idle");

    // Single requester Y for five cycles, then idle.
    for (int i = 0; i < 5; i++) ciclo(1'b0, 1'b0, 1'b1, 2'b10, "single_y");
    ciclo(1'b0, 1'b0, 1'b0, 2'b00, "single_y_drop");

    // Handoff X -> Y with no idle cycle.
    ciclo(1'b0, 1'b1, 1'b0, 2'b01, "handoff_x_grant");
    ciclo(1'b0, 1'b1, 1'b1, 2'b01, "handoff_y_waits");
    ciclo(1'b0, 1'b0, 1'b1, 2'b10, "handoff_to_y");
    ciclo(1'b0, 1'b0, 1'b0, 2'b00, "handoff_idle");

    // Tie after X was served last goes to Y.
    ciclo(1'b0, 1'b1, 1'b0, 2'b01, "rr_x_first");
    ciclo(1'b0, 1'b0, 1'b0, 2'b00, "rr_idle");
    ciclo(1'b0, 1'b1, 1'b1, 2'b10, "rr_tie_to_y");
    ciclo(1'b0, 1'b0, 1'b0, 2'b00, "rr_idle2");

    // Reset mid-grant drops the grant, then arbitration resumes.
    ciclo(1'b0, 1'b1, 1'b0, 2'b01, "midrst_grant");
    ciclo(1'b1, 1'b1, 1'b0, 2'b00, "midrst_drop");
    ciclo(1'b0, 1'b1, 1'b0, 2'b01, "midrst_resume");
    ciclo(1'b0, 1'b0, 1'b0, 2'b00, "midrst_idle");

`ifdef ARBITRO_LIMITE_RAFAGA_EN
    // X served last, so the tie starts on Y; 4-cycle bursts alternate.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) ciclo(1'b0, 1'b1, 1'b1, 2'b10, "burst_y");
      for (int i = 0; i < 4; i++) ciclo(1'b0, 1'b1, 1'b1, 2'b01, "burst_x");
    end
    // Counter saturated, Y absent: X keeps the grant.
    for (int i = 0; i < 3; i++) ciclo(1'b0, 1'b1, 1'b0, 2'b01, "sat_keep_x");
    // Y rises: switch on the very next edge.
    ciclo(1'b0, 1'b1, 1'b1, 2'b10, "sat_switch_y");
    ciclo(1'b0, 1'b0, 1'b0, 2'b00, "sat_idle");
`else
    // Reset makes X win the tie; without limiting X holds indefinitely.
    ciclo(1'b1, 1'b0, 1'b0, 2'b00, "nolim_reset");
    for (int i = 0; i < 20; i++) ciclo(1'b0, 1'b1, 1'b1, 2'b01, "nolim_hold_x");
    ciclo(1'b0, 1'b0, 1'b1, 2'b10, "nolim_drop_x");
    ciclo(1'b0, 1'b0, 1'b0, 2'b00, "nolim_idle");
`endif

    inv_en = 1'b0;
    @(posedge Reloj);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
